// File: rtl/cxu_arb_pkg.sv
// Shared CXU definitions: status width and encodings, plus small sizing helpers
// used by the arbiter and its ID FIFO.
package cxu_arb_pkg;

  localparam int CXU_STATUS_W = 3;

  typedef enum logic [CXU_STATUS_W-1:0] {
    CXU_STATUS_OK      = 3'd0,
    CXU_STATUS_ERROR   = 3'd1,
    CXU_STATUS_BUSY    = 3'd2,
    CXU_STATUS_OFF     = 3'd3,
    CXU_STATUS_INVALID = 3'd4
  } cxu_status_e;

  // Index of the highest set bit; 0 for an input of 0 or 1.
  function automatic int msb(input int unsigned v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int idx_w(input int n);
    return max(1, msb(unsigned'(n - 1)) + 1);
  endfunction

endpackage

// File: rtl/cxu_id_fifo.sv
// Requester-ID FIFO tracking outstanding CXU requests in issue order.
// Registered storage, head visible combinationally; caller never pushes when full or pops when empty.
module cxu_id_fifo
  import cxu_arb_pkg::*;
#(
  parameter int W     = 1,
  parameter int DEPTH = 4,
  localparam int PTR_W = idx_w(DEPTH),
  localparam int CNT_W = idx_w(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [W-1:0]     dat_i,
  input  logic             pop_i,
  output logic [W-1:0]     dat_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload needs no reset: the count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= dat_i;
  end

  assign dat_o   = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/cxu_arb.sv
// Round-robin arbiter sharing one CXU-LI target among N_REQ requesters; 1-cycle registered request path,
// responses routed in order via an ID FIFO; stalls on busy output register or DEPTH outstanding.
module cxu_arb
  import cxu_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int CXU_DATA_W     = 32,
  parameter int CXU_FUNC_ID_W  = 3,
  parameter int CXU_CXU_ID_W   = 2,
  parameter int CXU_STATE_ID_W = 1,
  parameter int DEPTH          = 4
) (
  input  logic                               CLK,
  input  logic                               rst_n,
  input  logic                               UserCLK_en,
  input  logic [N_REQ-1:0]                   r_req_valid,
  output logic [N_REQ-1:0]                   r_req_ready,
  input  logic [N_REQ*CXU_CXU_ID_W-1:0]      r_req_cxu,
  input  logic [N_REQ*CXU_STATE_ID_W-1:0]    r_req_state,
  input  logic [N_REQ*CXU_FUNC_ID_W-1:0]     r_req_func,
  input  logic [N_REQ*CXU_DATA_W-1:0]        r_req_data0,
  input  logic [N_REQ*CXU_DATA_W-1:0]        r_req_data1,
  output logic [N_REQ-1:0]                   r_resp_valid,
  input  logic [N_REQ-1:0]                   r_resp_ready,
  output logic [CXU_STATUS_W-1:0]            r_resp_status,
  output logic [CXU_DATA_W-1:0]              r_resp_data,
  output logic                               t_req_valid,
  input  logic                               t_req_ready,
  output logic [CXU_CXU_ID_W-1:0]            t_req_cxu,
  output logic [CXU_STATE_ID_W-1:0]          t_req_state,
  output logic [CXU_FUNC_ID_W-1:0]           t_req_func,
  output logic [CXU_DATA_W-1:0]              t_req_data0,
  output logic [CXU_DATA_W-1:0]              t_req_data1,
  input  logic                               t_resp_valid,
  output logic                               t_resp_ready,
  input  logic [CXU_STATUS_W-1:0]            t_resp_status,
  input  logic [CXU_DATA_W-1:0]              t_resp_data,
  output logic                               err_orphan
);

  localparam int ID_W  = idx_w(N_REQ);
  localparam int CNT_W = idx_w(DEPTH + 1);

  logic [ID_W-1:0]           last_grant_q, last_grant_d;
  logic                      t_vld_q, t_vld_d;
  logic [CXU_CXU_ID_W-1:0]   t_cxu_q, t_cxu_d;
  logic [CXU_STATE_ID_W-1:0] t_state_q, t_state_d;
  logic [CXU_FUNC_ID_W-1:0]  t_func_q, t_func_d;
  logic [CXU_DATA_W-1:0]     t_data0_q, t_data0_d;
  logic [CXU_DATA_W-1:0]     t_data1_q, t_data1_d;
  logic                      err_q, err_d;

  logic                      found;
  int                        sel_int;
  int                        cand;
  logic [ID_W-1:0]           sel;
  logic                      out_free;
  logic                      accept;
  logic                      pop;
  logic                      head_ok;
  logic [ID_W-1:0]           head_id;
  logic                      fifo_empty;
  logic [CNT_W-1:0]          id_cnt;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    found   = 1'b0;
    sel_int = 0;
    cand    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last_grant_q) + k) % N_REQ;
      if (!found && r_req_valid[cand]) begin
        found   = 1'b1;
        sel_int = cand;
      end
    end
  end

  assign sel      = ID_W'(sel_int);
  assign out_free = !t_vld_q || t_req_ready;
  assign accept   = UserCLK_en && found && out_free && (id_cnt < CNT_W'(DEPTH));

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      r_req_ready[i] = accept && (sel_int == i);
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    t_vld_d      = t_vld_q;
    t_cxu_d      = t_cxu_q;
    t_state_d    = t_state_q;
    t_func_d     = t_func_q;
    t_data0_d    = t_data0_q;
    t_data1_d    = t_data1_q;
    if (accept) begin
      last_grant_d = sel;
      t_vld_d      = 1'b1;
      t_cxu_d      = r_req_cxu[sel_int*CXU_CXU_ID_W +: CXU_CXU_ID_W];
      t_state_d    = r_req_state[sel_int*CXU_STATE_ID_W +: CXU_STATE_ID_W];
      t_func_d     = r_req_func[sel_int*CXU_FUNC_ID_W +: CXU_FUNC_ID_W];
      t_data0_d    = r_req_data0[sel_int*CXU_DATA_W +: CXU_DATA_W];
      t_data1_d    = r_req_data1[sel_int*CXU_DATA_W +: CXU_DATA_W];
    end else if (UserCLK_en && t_req_ready) begin
      t_vld_d = 1'b0;
    end
  end

  // Response side: the FIFO head names the requester owed the next response.
  assign head_ok      = UserCLK_en && !fifo_empty;
  assign t_resp_ready = head_ok && r_resp_ready[head_id];
  assign pop          = t_resp_valid && t_resp_ready;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      r_resp_valid[i] = head_ok && t_resp_valid && (head_id == ID_W'(i));
    end
  end

  assign err_d         = err_q || (UserCLK_en && t_resp_valid && fifo_empty);
  assign r_resp_status = t_resp_status;
  assign r_resp_data   = t_resp_data;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= ID_W'(N_REQ - 1);
      t_vld_q      <= 1'b0;
      t_cxu_q      <= '0;
      t_state_q    <= '0;
      t_func_q     <= '0;
      t_data0_q    <= '0;
      t_data1_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      t_vld_q      <= t_vld_d;
      t_cxu_q      <= t_cxu_d;
      t_state_q    <= t_state_d;
      t_func_q     <= t_func_d;
      t_data0_q    <= t_data0_d;
      t_data1_q    <= t_data1_d;
      err_q        <= err_d;
    end
  end

  cxu_id_fifo #(
    .W     (ID_W),
    .DEPTH (DEPTH)
  ) u_id_fifo (
    .clk_i   (CLK),
    .rst_ni  (rst_n),
    .push_i  (accept),
    .dat_i   (sel),
    .pop_i   (pop),
    .dat_o   (head_id),
    .empty_o (fifo_empty),
    .cnt_o   (id_cnt)
  );

  assign t_req_valid = t_vld_q;
  assign t_req_cxu   = t_cxu_q;
  assign t_req_state = t_state_q;
  assign t_req_func  = t_func_q;
  assign t_req_data0 = t_data0_q;
  assign t_req_data1 = t_data1_q;
  assign err_orphan  = err_q;

endmodule
